decade_sweep_arbiter: RTL and testbench

Shares one 1-to-LIMIT sweep counter (the decade counter, LIMIT=10 by default) among four requesters. Each granted requester owns the counter for exactly one full, non-preemptible sweep. Ownership rotates round-robin at sweep boundaries. The block sits between the requesting engines and the counter datapath: it sequences the counter, exposes the owner as a one-hot grant, and flags the final count of each sweep.

---
 rtl/decade_sweep_arbiter.sv | 116 +++++++++++
 tb/tb_decade_sweep_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decade_sweep_arbiter.sv
// decade_sweep_arbiter: four requesters share one 1..LIMIT sweep counter.
// Each grantee owns the counter for one full, non-preemptible sweep.
// Ownership rotates round-robin at sweep boundaries.
module decade_sweep_arbiter #(
   parameter int unsigned LIMIT = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       hold,
   output logic [3:0] grant,
   output logic [3:0] q,
   output logic       last,
   output logic       busy
);

   localparam logic [3:0] LIM = 4'(LIMIT);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q,   cnt_d;
   logic [3:0] grant_q, grant_d;
   logic [1:0] ptr_q,   ptr_d;
   logic       busy_q,  busy_d;

   logic [1:0] win;
   logic       win_found;

   // Round-robin search starting one past the most recent grantee
   always_comb begin
      win       = ptr_q;
      win_found = 1'b0;
      for (int unsigned i = 1; i <= 4; i++) begin
         logic [1:0] idx;
         idx = ptr_q + 2'(i);
         if (!win_found && req[idx]) begin
            win       = idx;
            win_found = 1'b1;
         end
      end
   end

   // Next-state logic: sweep sequencing and grant handover
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      if (!hold) begin
         unique case (state_q)
            IDLE: begin
               if (win_found) begin
                  state_d = RUN;
                  cnt_d   = 4'd1;
                  grant_d = 4'b0001 << win;
                  ptr_d   = win;
                  busy_d  = 1'b1;
               end else begin
                  cnt_d   = '0;
                  grant_d = '0;
                  busy_d  = 1'b0;
               end
            end
            RUN: begin
               if (cnt_q < LIM) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (win_found) begin
                  // back-to-back sweep, no idle cycle in between
                  cnt_d   = 4'd1;
                  grant_d = 4'b0001 << win;
                  ptr_d   = win;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  grant_d = '0;
                  busy_d  = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               grant_d = '0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         grant_q <= '0;
         ptr_q   <= 2'd3;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   assign grant = grant_q;
   assign q     = cnt_q;
   assign busy  = busy_q;
   assign last  = busy_q && (cnt_q == LIM);

endmodule

// File: tb/tb_decade_sweep_arbiter.sv
// Self-checking bench for decade_sweep_arbiter against an ownership/count model.
module tb_decade_sweep_arbiter;

   localparam int LIMIT = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic       hold;
   logic [3:0] grant;
   logic [3:0] q;
   logic       last;
   logic       busy;

   int errors = 0;
   int checks = 0;

   // model: owner index (-1 idle), count within sweep, last grantee
   int m_own = -1;
   int m_cnt = 0;
   int m_ptr = 3;

   decade_sweep_arbiter #(.LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .hold  (hold),
      .grant (grant),
      .q     (q),
      .last  (last),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input int ptr, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic rst, input logic [3:0] r, input logic h);
      int w;
      if (rst) begin
         m_own = -1; m_cnt = 0; m_ptr = 3;
      end else if (!h) begin
         if (m_own < 0 || m_cnt == LIMIT) begin
            w = pick(m_ptr, r);
            if (w >= 0) begin
               m_own = w; m_cnt = 1; m_ptr = w;
            end else begin
               m_own = -1; m_cnt = 0;
            end
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic step(input logic rst, input logic [3:0] r, input logic h);
      logic [3:0] eg;
      reset = rst; req = r; hold = h;
      @(posedge clk);
      #1;
      model_edge(rst, r, h);
      eg = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
      chk("grant", 8'(grant), 8'(eg));
      chk("q",     8'(q),     8'(m_cnt));
      chk("busy",  8'(busy),  8'(m_own >= 0));
      chk("last",  8'(last),  8'(m_own >= 0 && m_cnt == LIMIT));
   endtask

   initial begin
      int lasts;
      reset = 1'b1; req = '0; hold = 1'b0;

      // reset with all requests, then first grant goes to req[0]
      step(1'b1, 4'b1111, 1'b0);
      step(1'b1, 4'b1111, 1'b0);
      chk("reset_q", 8'(q), 8'd0);
      chk("reset_grant", 8'(grant), 8'd0);
      step(1'b0, 4'b1111, 1'b0);
      chk("first_grant", 8'(grant), 8'b0001);
      chk("first_q", 8'(q), 8'd1);

      // single requester: continuous sweeps, one last per sweep
      step(1'b1, 4'b0000, 1'b0);
      lasts = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 4'b0001, 1'b0);
         if (last) lasts++;
      end
      chk("solo_last_count", 8'(lasts), 8'd3);
      chk("solo_no_idle", 8'(busy), 8'd1);

      // all requesting: rotation 0001,0010,0100,1000,0001
      step(1'b1, 4'b0000, 1'b0);
      for (int i = 0; i < 41; i++) step(1'b0, 4'b1111, 1'b0);
      chk("rr_wrap_grant", 8'(grant), 8'b0001);

      // one-cycle pulse on req[1] from idle
      step(1'b1, 4'b0000, 1'b0);
      step(1'b0, 4'b0010, 1'b0);
      chk("pulse_grant", 8'(grant), 8'b0010);
      for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, 1'b0);
      chk("pulse_end_busy", 8'(busy), 8'd0);

      // hold for 3 cycles at q=4
      step(1'b1, 4'b0000, 1'b0);
      step(1'b0, 4'b0001, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 1'b1);
      chk("hold_q", 8'(q), 8'd4);
      for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, 1'b0);
      chk("hold_last", 8'(last), 8'd1);
      step(1'b0, 4'b0000, 1'b0);

      // hold in idle blocks new grants
      for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 1'b1);
      chk("hold_idle_grant", 8'(grant), 8'd0);

      // reset mid-sweep while grant=0100, q=6
      step(1'b1, 4'b0000, 1'b0);
      for (int i = 0; i < 26; i++) step(1'b0, 4'b1111, 1'b0);
      chk("pre_reset_grant", 8'(grant), 8'b0100);
      chk("pre_reset_q", 8'(q), 8'd6);
      step(1'b1, 4'b1111, 1'b1);
      step(1'b0, 4'b1111, 1'b0);
      chk("post_reset_grant", 8'(grant), 8'b0001);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) == 0), 4'($urandom), ($urandom_range(0, 4) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
